// File: rtl/ara_req_bcast.sv
// rtl/ara_req_bcast.sv - fork CVA6 accelerator requests to NrClusters Ara clusters and join responses
// Optional ARA_BCAST_MISMATCH_EN adds a sticky trans_id mismatch flag (mismatch_o).
package ara_bcast_pkg;
    typedef struct packed {
        logic        valid;
        logic [5:0]  cause;
        logic [31:0] tval;
    } exception_t;

    typedef struct packed {
        logic        req_valid;
        logic        resp_ready;
        logic [31:0] insn;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [2:0]  frm;
        logic [2:0]  trans_id;
        logic        store_pending;
        logic        acc_cons_en;
        logic        inval_ready;
    } accelerator_req_t;

    typedef struct packed {
        logic        req_ready;
        logic        resp_valid;
        logic [63:0] result;
        logic [2:0]  trans_id;
        exception_t  exception;
        logic [4:0]  fflags;
        logic        fflags_valid;
        logic        store_pending;
        logic        store_complete;
        logic        load_complete;
        logic        inval_valid;
        logic [63:0] inval_addr;
    } accelerator_resp_t;
endpackage

module ara_req_bcast
    import ara_bcast_pkg::*;
#(
    parameter int unsigned NrClusters = 4,
    parameter int unsigned CntWidth   = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  accelerator_req_t                   acc_req_i,
    output accelerator_resp_t                  acc_resp_o,
    output accelerator_req_t  [NrClusters-1:0] acc_req_o,
    input  accelerator_resp_t [NrClusters-1:0] acc_resp_i
`ifdef ARA_BCAST_MISMATCH_EN
    ,
    output logic                               mismatch_o
`endif
);

    localparam int unsigned IdxWidth = (NrClusters > 1) ? $clog2(NrClusters) : 1;

    typedef struct packed {
        logic [63:0] result;
        logic [2:0]  trans_id;
        exception_t  exception;
        logic [4:0]  fflags;
        logic        fflags_valid;
    } rdata_t;

    logic [NrClusters-1:0]                sent_q, ready_c, fork_hs, sp_c;
    logic [NrClusters-1:0]                rvalid_q;
    rdata_t [NrClusters-1:0]              rdata_q;
    logic [NrClusters-1:0][CntWidth-1:0]  ld_cnt_q, st_cnt_q;
    logic                                 store_pending_q, lock_q;
    logic [IdxWidth-1:0]                  gnt_q, gnt;
    logic                                 req_hs, resp_hs, ld_fire, st_fire;

    // Fixed-priority invalidation arbiter; a pending grant is held until CVA6 accepts it.
    always_comb begin
        gnt = '0;
        if (lock_q) begin
            gnt = gnt_q;
        end else begin
            for (int c = int'(NrClusters) - 1; c >= 0; c--) begin
                if (acc_resp_i[c].inval_valid) gnt = IdxWidth'(c);
            end
        end
    end

    always_comb begin
        ld_fire = 1'b1;
        st_fire = 1'b1;
        for (int c = 0; c < NrClusters; c++) begin
            ready_c[c]                = acc_resp_i[c].req_ready;
            sp_c[c]                   = acc_resp_i[c].store_pending;
            acc_req_o[c]              = acc_req_i;
            acc_req_o[c].req_valid    = acc_req_i.req_valid & ~sent_q[c];
            acc_req_o[c].resp_ready   = ~rvalid_q[c];
            acc_req_o[c].inval_ready  = acc_req_i.inval_ready & (gnt == IdxWidth'(c));
            fork_hs[c]                = acc_req_o[c].req_valid & acc_resp_i[c].req_ready;
            if (ld_cnt_q[c] == '0) ld_fire = 1'b0;
            if (st_cnt_q[c] == '0) st_fire = 1'b0;
        end
    end

    always_comb begin
        acc_resp_o                = '0;
        acc_resp_o.req_ready      = &(sent_q | ready_c);
        acc_resp_o.resp_valid     = &rvalid_q;
        acc_resp_o.result         = rdata_q[0].result;
        acc_resp_o.trans_id       = rdata_q[0].trans_id;
        acc_resp_o.exception      = rdata_q[0].exception;
        for (int c = int'(NrClusters) - 1; c >= 0; c--) begin
            if (rdata_q[c].exception.valid) acc_resp_o.exception = rdata_q[c].exception;
        end
        for (int c = 0; c < NrClusters; c++) begin
            acc_resp_o.fflags       = acc_resp_o.fflags | rdata_q[c].fflags;
            acc_resp_o.fflags_valid = acc_resp_o.fflags_valid | rdata_q[c].fflags_valid;
        end
        acc_resp_o.store_pending  = store_pending_q;
        acc_resp_o.load_complete  = ld_fire;
        acc_resp_o.store_complete = st_fire;
        acc_resp_o.inval_valid    = acc_resp_i[gnt].inval_valid;
        acc_resp_o.inval_addr     = acc_resp_i[gnt].inval_addr;
    end

    assign req_hs  = acc_req_i.req_valid & acc_resp_o.req_ready;
    assign resp_hs = acc_req_i.resp_ready & acc_resp_o.resp_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sent_q          <= '0;
            rvalid_q        <= '0;
            rdata_q         <= '0;
            ld_cnt_q        <= '0;
            st_cnt_q        <= '0;
            store_pending_q <= 1'b0;
            lock_q          <= 1'b0;
            gnt_q           <= '0;
        end else begin
            sent_q <= req_hs ? '0 : (sent_q | fork_hs);
            for (int c = 0; c < NrClusters; c++) begin
                if (resp_hs) begin
                    rvalid_q[c] <= 1'b0;
                end else if (acc_resp_i[c].resp_valid && !rvalid_q[c]) begin
                    rvalid_q[c] <= 1'b1;
                    rdata_q[c]  <= '{result:       acc_resp_i[c].result,
                                     trans_id:     acc_resp_i[c].trans_id,
                                     exception:    acc_resp_i[c].exception,
                                     fflags:       acc_resp_i[c].fflags,
                                     fflags_valid: acc_resp_i[c].fflags_valid};
                end
                ld_cnt_q[c] <= ld_cnt_q[c] + CntWidth'(acc_resp_i[c].load_complete)
                               - CntWidth'(ld_fire);
                st_cnt_q[c] <= st_cnt_q[c] + CntWidth'(acc_resp_i[c].store_complete)
                               - CntWidth'(st_fire);
            end
            store_pending_q <= |sp_c;
            lock_q          <= acc_resp_o.inval_valid & ~acc_req_i.inval_ready;
            gnt_q           <= gnt;
        end
    end

`ifdef ARA_BCAST_MISMATCH_EN
    logic mismatch_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mismatch_q <= 1'b0;
        end else if (resp_hs) begin
            for (int c = 1; c < NrClusters; c++) begin
                if (rdata_q[c].trans_id != rdata_q[0].trans_id) mismatch_q <= 1'b1;
            end
        end
    end
    assign mismatch_o = mismatch_q;
`endif

`ifndef SYNTHESIS
    // Completion counters are sized so that saturation means the clusters have drifted apart.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int c = 0; c < NrClusters; c++) begin
                assert (!(acc_resp_i[c].load_complete && !ld_fire && ld_cnt_q[c] == '1));
                assert (!(acc_resp_i[c].store_complete && !st_fire && st_cnt_q[c] == '1));
            end
        end
    end
`endif

endmodule

// File: tb/tb_ara_req_bcast.sv
// tb/tb_ara_req_bcast.sv - directed self-checking bench for ara_req_bcast
module tb_ara_req_bcast;
    import ara_bcast_pkg::*;

    localparam int N = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    accelerator_req_t          acc_req_i;
    accelerator_resp_t         acc_resp_o;
    accelerator_req_t  [N-1:0] acc_req_o;
    accelerator_resp_t [N-1:0] acc_resp_i;
`ifdef ARA_BCAST_MISMATCH_EN
    logic                      mismatch;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int beats [N];

    always #5 clk = ~clk;

    ara_req_bcast #(.NrClusters(N), .CntWidth(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .acc_req_i  (acc_req_i),
        .acc_resp_o (acc_resp_o),
        .acc_req_o  (acc_req_o),
        .acc_resp_i (acc_resp_i)
`ifdef ARA_BCAST_MISMATCH_EN
        ,
        .mismatch_o (mismatch)
`endif
    );

    initial for (int c = 0; c < N; c++) beats[c] = 0;

    always @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < N; c++) begin
                if (acc_req_o[c].req_valid && acc_resp_i[c].req_ready) beats[c] <= beats[c] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int ord [4];
        ord[0] = 3; ord[1] = 1; ord[2] = 0; ord[3] = 2;
        acc_req_i  = '0;
        acc_resp_i = '0;

        // reset state
        #1;
        chk("rst_req_ready_low", acc_resp_o.req_ready, 0);
        for (int c = 0; c < N; c++) acc_resp_i[c].req_ready = 1'b1;
        #1;
        chk("rst_req_ready_follows", acc_resp_o.req_ready, 1);
        chk("rst_resp_valid", acc_resp_o.resp_valid, 0);
        chk("rst_inval_valid", acc_resp_o.inval_valid, 0);
        chk("rst_load_complete", acc_resp_o.load_complete, 0);
        chk("rst_store_pending", acc_resp_o.store_pending, 0);
`ifdef ARA_BCAST_MISMATCH_EN
        chk("rst_mismatch", mismatch, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single request, all clusters ready
        @(negedge clk);
        acc_req_i.req_valid = 1'b1;
        acc_req_i.insn      = 32'h1234_5678;
        #1;
        chk("t1_req_ready", acc_resp_o.req_ready, 1);
        for (int c = 0; c < N; c++) chk($sformatf("t1_fork_valid%0d", c), acc_req_o[c].req_valid, 1);
        chk("t1_insn_bcast", acc_req_o[2].insn, 64'h1234_5678);
        @(negedge clk);
        acc_req_i.req_valid = 1'b0;
        for (int c = 0; c < N; c++) acc_resp_i[c].req_ready = 1'b0;
        #1;
        for (int c = 0; c < N; c++) chk($sformatf("t1_beats%0d", c), beats[c], 1);

        // staggered readiness: clusters ready on cycles 0,2,5,5
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            acc_req_i.req_valid     = 1'b1;
            acc_resp_i[0].req_ready = (k == 0);
            acc_resp_i[1].req_ready = (k == 2);
            acc_resp_i[2].req_ready = (k == 5);
            acc_resp_i[3].req_ready = (k == 5);
            #1;
            chk($sformatf("t2_req_ready_k%0d", k), acc_resp_o.req_ready, (k == 5));
            chk($sformatf("t2_c0_valid_k%0d", k), acc_req_o[0].req_valid, (k == 0));
        end
        @(negedge clk);
        acc_req_i.req_valid = 1'b0;
        for (int c = 0; c < N; c++) acc_resp_i[c].req_ready = 1'b0;
        #1;
        for (int c = 0; c < N; c++) chk($sformatf("t2_beats%0d", c), beats[c], 2);

        // response join: clusters 3,1,0,2 on cycles 0..3
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) acc_resp_i[c].resp_valid = 1'b0;
            acc_resp_i[ord[k]].resp_valid       = 1'b1;
            acc_resp_i[ord[k]].fflags           = 5'(1 << ord[k]);
            acc_resp_i[ord[k]].fflags_valid     = (ord[k] == 1);
            acc_resp_i[ord[k]].trans_id         = 3'd3;
            acc_resp_i[ord[k]].result           = (ord[k] == 0) ? 64'hABCD : 64'hDEAD0 + 64'(ord[k]);
            acc_resp_i[ord[k]].exception.valid  = (ord[k] >= 2);
            acc_resp_i[ord[k]].exception.cause  = 6'(ord[k] + 3);
            #1;
            chk($sformatf("t3_resp_valid_k%0d", k), acc_resp_o.resp_valid, 0);
        end
        @(negedge clk);
        for (int c = 0; c < N; c++) acc_resp_i[c].resp_valid = 1'b0;
        #1;
        chk("t3_resp_valid", acc_resp_o.resp_valid, 1);
        chk("t3_fflags", acc_resp_o.fflags, 5'hF);
        chk("t3_fflags_valid", acc_resp_o.fflags_valid, 1);
        chk("t3_exc_valid", acc_resp_o.exception.valid, 1);
        chk("t3_exc_cause", acc_resp_o.exception.cause, 5);
        chk("t3_result", acc_resp_o.result, 64'hABCD);
        chk("t3_trans_id", acc_resp_o.trans_id, 3);
        chk("t3_c2_resp_ready", acc_req_o[2].resp_ready, 0);
        @(negedge clk);
        #1;
        chk("t3_hold", acc_resp_o.resp_valid, 1);
        acc_req_i.resp_ready = 1'b1;
        @(negedge clk);
        acc_req_i.resp_ready = 1'b0;
        #1;
        chk("t3_cleared", acc_resp_o.resp_valid, 0);
        chk("t3_c0_resp_ready", acc_req_o[0].resp_ready, 1);
`ifdef ARA_BCAST_MISMATCH_EN
        chk("t3_no_mismatch", mismatch, 0);
`endif

        // completion pulses: cluster 0 x3, then clusters 1,2,3 one each
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) acc_resp_i[c].load_complete = 1'b0;
            if (k < 3) acc_resp_i[0].load_complete = 1'b1;
            else if (k < 6) acc_resp_i[k-2].load_complete = 1'b1;
            #1;
            chk($sformatf("t4_load_complete_k%0d", k), acc_resp_o.load_complete, (k == 6));
            chk($sformatf("t4_store_complete_k%0d", k), acc_resp_o.store_complete, 0);
        end
        chk("t4_c0_count", dut.ld_cnt_q[0], 2);

        // invalidation: clusters 1 and 2 together, CVA6 stalls 3 cycles
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            acc_resp_i[1].inval_valid = (k < 4);
            acc_resp_i[1].inval_addr  = 64'h1000;
            acc_resp_i[2].inval_valid = (k < 5);
            acc_resp_i[2].inval_addr  = 64'h2000;
            acc_resp_i[0].inval_valid = (k == 1 || k == 2);
            acc_resp_i[0].inval_addr  = 64'h0AAA;
            acc_req_i.inval_ready     = (k == 3 || k == 4);
            #1;
            if (k < 4) begin
                chk($sformatf("t5_addr_k%0d", k), acc_resp_o.inval_addr, 64'h1000);
                chk($sformatf("t5_c1_ready_k%0d", k), acc_req_o[1].inval_ready, (k == 3));
                chk($sformatf("t5_c2_ready_k%0d", k), acc_req_o[2].inval_ready, 0);
            end else if (k == 4) begin
                chk("t5_addr_c2", acc_resp_o.inval_addr, 64'h2000);
                chk("t5_c2_ready", acc_req_o[2].inval_ready, 1);
            end
            chk($sformatf("t5_valid_k%0d", k), acc_resp_o.inval_valid, (k < 5));
        end
        acc_req_i.inval_ready = 1'b0;

        // sideband broadcast and registered store_pending
        @(negedge clk);
        acc_resp_i[2].store_pending = 1'b1;
        acc_req_i.store_pending     = 1'b1;
        acc_req_i.acc_cons_en       = 1'b1;
        #1;
        chk("t6_sp_delay", acc_resp_o.store_pending, 0);
        chk("t6_sp_bcast", acc_req_o[3].store_pending, 1);
        chk("t6_cons_bcast", acc_req_o[1].acc_cons_en, 1);
        @(negedge clk);
        acc_resp_i[2].store_pending = 1'b0;
        #1;
        chk("t6_sp_set", acc_resp_o.store_pending, 1);
        @(negedge clk);
        #1;
        chk("t6_sp_clear", acc_resp_o.store_pending, 0);

`ifdef ARA_BCAST_MISMATCH_EN
        // trans_id mismatch on cluster 3
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            acc_resp_i[c].resp_valid = 1'b1;
            acc_resp_i[c].trans_id   = (c == 3) ? 3'd5 : 3'd2;
        end
        @(negedge clk);
        for (int c = 0; c < N; c++) acc_resp_i[c].resp_valid = 1'b0;
        #1;
        chk("t7_resp_valid", acc_resp_o.resp_valid, 1);
        chk("t7_mismatch_pre", mismatch, 0);
        acc_req_i.resp_ready = 1'b1;
        @(negedge clk);
        acc_req_i.resp_ready = 1'b0;
        #1;
        chk("t7_mismatch_set", mismatch, 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t7_mismatch_sticky", mismatch, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
